// File: rtl/alu_responder.sv
// Registered, handshaked responder front-end for the 32-bit ALU (IDLE -> EXEC -> RESP).
// Optional sticky overflow status register and its ports are built only when ALU_STICKY_OVF_EN is defined.
module alu_responder (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic [2:0]  command,
   input  logic [3:0]  req_tag,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] result,
   output logic        carryout,
   output logic        overflow,
   output logic        zero,
   output logic [3:0]  resp_tag
`ifdef ALU_STICKY_OVF_EN
   ,
   input  logic        clr_sticky,
   output logic        sticky_ovf
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [2:0] CMD_ADD  = 3'b000;
   localparam logic [2:0] CMD_SUB  = 3'b001;
   localparam logic [2:0] CMD_XOR  = 3'b010;
   localparam logic [2:0] CMD_SLT  = 3'b011;
   localparam logic [2:0] CMD_AND  = 3'b100;
   localparam logic [2:0] CMD_NAND = 3'b101;
   localparam logic [2:0] CMD_NOR  = 3'b110;
   localparam logic [2:0] CMD_OR   = 3'b111;

   logic [1:0]  state;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [2:0]  cmd_q;
   logic [3:0]  tag_q;

   logic        accept;
   logic        consume;
   logic        is_sub;
   logic [31:0] adder_b;
   logic [32:0] sum;
   logic        adder_ovf;
   logic [31:0] alu_result;
   logic        alu_carry;
   logic        alu_ovf;

   assign accept     = (state == ST_IDLE) && req_valid;
   assign consume    = (state == ST_RESP) && resp_ready;
   assign req_ready  = (state == ST_IDLE) && !reset;
   assign resp_valid = (state == ST_RESP);

   // SUB and SLT share the adder in subtract mode (A + ~B + 1).
   assign is_sub    = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
   assign adder_b   = is_sub ? ~b_q : b_q;
   assign sum       = {1'b0, a_q} + {1'b0, adder_b} + {32'd0, is_sub};
   assign adder_ovf = (a_q[31] == adder_b[31]) && (sum[31] != a_q[31]);

   always_comb begin
      alu_result = 32'd0;
      alu_carry  = 1'b0;
      alu_ovf    = 1'b0;
      case (cmd_q)
         CMD_ADD, CMD_SUB: begin
            alu_result = sum[31:0];
            alu_carry  = sum[32];
            alu_ovf    = adder_ovf;
         end
         CMD_SLT:  alu_result = {31'd0, sum[31] ^ adder_ovf};
         CMD_XOR:  alu_result = a_q ^ b_q;
         CMD_AND:  alu_result = a_q & b_q;
         CMD_NAND: alu_result = ~(a_q & b_q);
         CMD_NOR:  alu_result = ~(a_q | b_q);
         CMD_OR:   alu_result = a_q | b_q;
         default:  alu_result = 32'd0;
      endcase
   end

   // Request fields are captured only on the accepting edge so later input changes cannot leak in.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         cmd_q <= 3'd0;
         tag_q <= 4'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q   <= operandA;
                  b_q   <= operandB;
                  cmd_q <= command;
                  tag_q <= req_tag;
                  state <= ST_EXEC;
               end
            end
            ST_EXEC: state <= ST_RESP;
            ST_RESP: begin
               if (consume) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Response registers load only when leaving EXEC and are otherwise held.
   always_ff @(posedge clk) begin
      if (reset) begin
         result   <= 32'd0;
         carryout <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         resp_tag <= 4'd0;
      end else if (state == ST_EXEC) begin
         result   <= alu_result;
         carryout <= alu_carry;
         overflow <= alu_ovf;
         zero     <= (alu_result == 32'd0);
         resp_tag <= tag_q;
      end
   end

`ifdef ALU_STICKY_OVF_EN
   // A consumed overflowing response wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_ovf <= 1'b0;
      end else if (consume && overflow) begin
         sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed cases, handshake timing, reset and randomized traffic.
// Sticky overflow checks are compiled in when ALU_STICKY_OVF_EN is defined.
module tb_alu_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic [2:0]  command = '0;
   logic [3:0]  req_tag = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] result;
   logic        carryout;
   logic        overflow;
   logic        zero;
   logic [3:0]  resp_tag;
`ifdef ALU_STICKY_OVF_EN
   logic        clr_sticky = 1'b0;
   logic        sticky_ovf;
   logic        exp_sticky = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_responder dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .operandA   (operandA),
      .operandB   (operandB),
      .command    (command),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .result     (result),
      .carryout   (carryout),
      .overflow   (overflow),
      .zero       (zero),
      .resp_tag   (resp_tag)
`ifdef ALU_STICKY_OVF_EN
      ,
      .clr_sticky (clr_sticky),
      .sticky_ovf (sticky_ovf)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: signed/unsigned arithmetic on wide integers, not an adder model.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                                 output logic [31:0] r, output logic co, output logic ov);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint s;
      co = 1'b0;
      ov = 1'b0;
      case (c)
         3'd0: begin
            r = a + b;
            co = ((longint'(a) + longint'(b)) > 64'sd4294967295);
            s = sa + sb;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: begin
            r = a - b;
            co = (a >= b);
            s = sa - sb;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd2: r = a ^ b;
         3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
   endfunction

   // Drives a request and returns just after the accepting edge (DUT in EXEC).
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input logic [3:0] t);
      int n = 0;
      operandA = a;
      operandB = b;
      command = c;
      req_tag = t;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL accept_timeout req_ready=%b required 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic consume(input logic ovf);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
`ifdef ALU_STICKY_OVF_EN
      if (ovf) exp_sticky = 1'b1;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if ({req_ready, resp_valid, result, carryout, overflow, zero, resp_tag} !== 41'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got rdy=%b vld=%b res=%h c=%b o=%b z=%b tag=%h required all 0",
                  req_ready, resp_valid, result, carryout, overflow, zero, resp_tag);
      end
`ifdef ALU_STICKY_OVF_EN
      exp_sticky = 1'b0;
      checks++;
      if (sticky_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_sticky got %b required 0", sticky_ovf);
      end
`endif
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready got %b required 1", req_ready);
      end
   endtask

   task automatic test_directed();
      logic [31:0] ta[10];
      logic [31:0] tb[10];
      logic [2:0]  tc[10];
      logic [31:0] tr[10];
      logic [2:0]  tf[10];
      ta[0] = 32'h7FFFFFFF; tb[0] = 32'h1;        tc[0] = 3'd0; tr[0] = 32'h80000000; tf[0] = 3'b010;
      ta[1] = 32'd5;        tb[1] = 32'd5;        tc[1] = 3'd1; tr[1] = 32'h0;        tf[1] = 3'b101;
      ta[2] = 32'hFFFFFFFF; tb[2] = 32'h1;        tc[2] = 3'd0; tr[2] = 32'h0;        tf[2] = 3'b101;
      ta[3] = 32'hFFFFFFFF; tb[3] = 32'h1;        tc[3] = 3'd3; tr[3] = 32'h1;        tf[3] = 3'b000;
      ta[4] = 32'h1;        tb[4] = 32'hFFFFFFFF; tc[4] = 3'd3; tr[4] = 32'h0;        tf[4] = 3'b001;
      ta[5] = 32'hF0F0F0F0; tb[5] = 32'hFFFF0000; tc[5] = 3'd5; tr[5] = 32'h0F0FFFFF; tf[5] = 3'b000;
      ta[6] = 32'h0;        tb[6] = 32'h0;        tc[6] = 3'd6; tr[6] = 32'hFFFFFFFF; tf[6] = 3'b000;
      ta[7] = 32'hAAAA5555; tb[7] = 32'hFFFF0000; tc[7] = 3'd2; tr[7] = 32'h55555555; tf[7] = 3'b000;
      ta[8] = 32'h12345678; tb[8] = 32'h0F0F0F0F; tc[8] = 3'd4; tr[8] = 32'h02040608; tf[8] = 3'b000;
      ta[9] = 32'h00FF0000; tb[9] = 32'h0000FF00; tc[9] = 3'd7; tr[9] = 32'h00FFFF00; tf[9] = 3'b000;
      for (int i = 0; i < 10; i++) begin
         logic [3:0] tag;
         tag = (i == 0) ? 4'd3 : 4'(i + 4);
         send(ta[i], tb[i], tc[i], tag);
         checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exec_handshake case %0d vld=%b rdy=%b required 0 0", i, resp_valid, req_ready);
         end
         tick();
         checks++;
         if (resp_valid !== 1'b1 || result !== tr[i] || {carryout, overflow, zero} !== tf[i] || resp_tag !== tag) begin
            errors++;
            $display("[TB] FAIL directed case %0d got vld=%b res=%h coz=%b tag=%h required 1 %h %b %h",
                     i, resp_valid, result, {carryout, overflow, zero}, resp_tag, tr[i], tf[i], tag);
         end
         consume(tf[i][1]);
         checks++;
         if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL consume_idle case %0d rdy=%b vld=%b required 1 0", i, req_ready, resp_valid);
         end
`ifdef ALU_STICKY_OVF_EN
         checks++;
         if (sticky_ovf !== exp_sticky) begin
            errors++;
            $display("[TB] FAIL directed_sticky case %0d got %b required %b", i, sticky_ovf, exp_sticky);
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      send(32'h00001234, 32'h00000F00, 3'd0, 4'hB);
      tick();
      for (int i = 0; i < 5; i++) begin
         operandA = $urandom;
         operandB = $urandom;
         command = 3'($urandom);
         req_tag = 4'($urandom);
         req_valid = ~req_valid;
         tick();
         checks++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || result !== 32'h00002134 ||
             {carryout, overflow, zero} !== 3'b000 || resp_tag !== 4'hB) begin
            errors++;
            $display("[TB] FAIL backpressure cycle %0d vld=%b rdy=%b res=%h coz=%b tag=%h required 1 0 00002134 000 b",
                     i, resp_valid, req_ready, result, {carryout, overflow, zero}, resp_tag);
         end
      end
      req_valid = 1'b0;
      consume(1'b0);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL backpressure_release rdy=%b vld=%b required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_reset_midflight();
      send(32'h0000FFFF, 32'h00000001, 3'd7, 4'h6);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'd0 || {carryout, overflow, zero} !== 3'b000 ||
          resp_tag !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_in_exec vld=%b rdy=%b res=%h coz=%b tag=%h required 0 1 0 000 0",
                  resp_valid, req_ready, result, {carryout, overflow, zero}, resp_tag);
      end
      send(32'h80000000, 32'h80000000, 3'd0, 4'h9);
      tick();
      reset = 1'b1;
      resp_ready = 1'b1;
      tick();
      reset = 1'b0;
      resp_ready = 1'b0;
      #1;
`ifdef ALU_STICKY_OVF_EN
      exp_sticky = 1'b0;
      checks++;
      if (sticky_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_in_resp_sticky got %b required 0", sticky_ovf);
      end
`endif
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || result !== 32'd0 || {carryout, overflow, zero} !== 3'b000 ||
          resp_tag !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_in_resp vld=%b rdy=%b res=%h coz=%b tag=%h required 0 1 0 000 0",
                  resp_valid, req_ready, result, {carryout, overflow, zero}, resp_tag);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] pattern[3];
      pattern[0] = 2'b00;
      pattern[1] = 2'b01;
      pattern[2] = 2'b10;
      operandA = 32'd7;
      operandB = 32'd2;
      command = 3'd1;
      req_tag = 4'h1;
      req_valid = 1'b1;
      resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if ({req_ready, resp_valid} !== pattern[i % 3]) begin
            errors++;
            $display("[TB] FAIL back_to_back cycle %0d rdy_vld=%b required %b", i, {req_ready, resp_valid}, pattern[i % 3]);
         end
      end
      req_valid = 1'b0;
      resp_ready = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL back_to_back_end rdy=%b vld=%b required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, er;
      logic [2:0]  c;
      logic [3:0]  t;
      logic        eco, eov;
      int          stall;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'h7FFFFFFF;
            1: a = 32'h80000000;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? a : $urandom;
         c = 3'($urandom);
         t = 4'($urandom);
         model(a, b, c, er, eco, eov);
         send(a, b, c, t);
         operandA = ~a;
         operandB = $urandom;
         command = ~c;
         req_tag = ~t;
         tick();
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1;
            tick();
         end
         req_valid = 1'b0;
         checks++;
         if (resp_valid !== 1'b1 || result !== er || carryout !== eco || overflow !== eov ||
             zero !== (er == 32'd0) || resp_tag !== t) begin
            errors++;
            $display("[TB] FAIL random %0d cmd=%0d a=%h b=%h got vld=%b res=%h c=%b o=%b z=%b tag=%h required 1 %h %b %b %b %h",
                     i, c, a, b, resp_valid, result, carryout, overflow, zero, resp_tag, er, eco, eov, er == 32'd0, t);
         end
         consume(eov);
`ifdef ALU_STICKY_OVF_EN
         checks++;
         if (sticky_ovf !== exp_sticky) begin
            errors++;
            $display("[TB] FAIL random_sticky %0d got %b required %b", i, sticky_ovf, exp_sticky);
         end
`endif
      end
   endtask

`ifdef ALU_STICKY_OVF_EN
   task automatic test_sticky();
      send(32'h7FFFFFFF, 32'h1, 3'd0, 4'h2);
      tick();
      consume(1'b1);
      checks++;
      if (sticky_ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sticky_set got %b required 1", sticky_ovf);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      exp_sticky = 1'b0;
      checks++;
      if (sticky_ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sticky_clear got %b required 0", sticky_ovf);
      end
      send(32'h80000000, 32'h1, 3'd1, 4'h4);
      tick();
      clr_sticky = 1'b1;
      consume(1'b1);
      clr_sticky = 1'b0;
      checks++;
      if (sticky_ovf !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sticky_set_beats_clear got %b required 1", sticky_ovf);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
      test_back_to_back();
`ifdef ALU_STICKY_OVF_EN
      test_sticky();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
